// File: rtl/code_lock_fsm.sv
//------------------------------------------------------------------------------
// Module   : code_lock_fsm
// Brief    : Digit-entry code lock with retry limit, timed lockout and optional
//            auto-relock (enable with CODE_LOCK_AUTORELOCK_EN).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module code_lock_fsm #(
    parameter int DIGIT_W     = 4,
    parameter int CODE_LEN    = 4,
    parameter int MAX_TRIES   = 3,
    parameter int LOCKOUT_CYC = 16,
    parameter int UNLOCK_CYC  = 8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                digit_valid,
    input  logic [DIGIT_W-1:0]                  digit,
    input  logic [CODE_LEN*DIGIT_W-1:0]         code,
    input  logic                                clear,
    output logic [2:0]                          state,
    output logic                                unlocked,
    output logic                                error,
    output logic                                lockout,
    output logic [$clog2(CODE_LEN+1)-1:0]       digit_count,
    output logic [$clog2(MAX_TRIES+1)-1:0]      tries_left
);

    localparam int c_CNT_W   = $clog2(CODE_LEN + 1);
    localparam int c_TRY_W   = $clog2(MAX_TRIES + 1);
    // One timer serves lockout and auto-relock; the two states never overlap.
    localparam int c_TMR_MAX = (LOCKOUT_CYC > UNLOCK_CYC) ? LOCKOUT_CYC : UNLOCK_CYC;
    localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_LAST_IDX  = c_CNT_W'(CODE_LEN - 1);
    localparam logic [c_TRY_W-1:0] c_MAX_TRIES = c_TRY_W'(MAX_TRIES);
    localparam logic [c_TMR_W-1:0] c_LOCK_LOAD = c_TMR_W'(LOCKOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_LOCKED   = 3'b000,
        S_INPUT    = 3'b001,
        S_VERIFY   = 3'b010,
        S_ERROR    = 3'b011,
        S_UNLOCKED = 3'b100,
        S_LOCKOUT  = 3'b101
    } state_t;

    state_t                        r_state;
    logic [CODE_LEN*DIGIT_W-1:0]   r_buf;
    logic [c_CNT_W-1:0]            r_count;
    logic [c_TRY_W-1:0]            r_tries;
    logic [c_TMR_W-1:0]            r_tmr;

    state_t                        w_state_nxt;
    logic [c_CNT_W-1:0]            w_count_nxt;
    logic [c_TRY_W-1:0]            w_tries_nxt;
    logic [c_TMR_W-1:0]            w_tmr_nxt;
    logic                          w_wr_en;
    logic [c_CNT_W-1:0]            w_wr_idx;
    logic [c_TRY_W-1:0]            w_tries_dec;

    assign w_tries_dec = r_tries - c_TRY_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_tries_nxt = r_tries;
        w_tmr_nxt   = r_tmr;
        w_wr_en     = 1'b0;
        w_wr_idx    = r_count;
        case (r_state)
            S_LOCKED: begin
                w_count_nxt = '0;
                if (!clear && digit_valid) begin
                    w_wr_en  = 1'b1;
                    w_wr_idx = '0;
                    if (CODE_LEN == 1) begin
                        w_state_nxt = S_VERIFY;
                    end else begin
                        w_state_nxt = S_INPUT;
                        w_count_nxt = c_CNT_W'(1);
                    end
                end
            end
            S_INPUT: begin
                if (clear) begin
                    w_state_nxt = S_LOCKED;
                    w_count_nxt = '0;
                end else if (digit_valid) begin
                    w_wr_en = 1'b1;
                    if (r_count == c_LAST_IDX) begin
                        w_state_nxt = S_VERIFY;
                        w_count_nxt = '0;
                    end else begin
                        w_count_nxt = r_count + c_CNT_W'(1);
                    end
                end
            end
            S_VERIFY: begin
                w_count_nxt = '0;
                if (r_buf == code) begin
                    w_state_nxt = S_UNLOCKED;
                    w_tries_nxt = c_MAX_TRIES;
`ifdef CODE_LOCK_AUTORELOCK_EN
                    w_tmr_nxt   = c_TMR_W'(UNLOCK_CYC - 1);
`endif
                end else begin
                    w_tries_nxt = w_tries_dec;
                    if (w_tries_dec == '0) begin
                        w_state_nxt = S_LOCKOUT;
                        w_tmr_nxt   = c_LOCK_LOAD;
                    end else begin
                        w_state_nxt = S_ERROR;
                    end
                end
            end
            S_ERROR: begin
                w_count_nxt = '0;
                w_state_nxt = S_LOCKED;
            end
            S_UNLOCKED: begin
                w_count_nxt = '0;
                if (clear) begin
                    w_state_nxt = S_LOCKED;
                end
`ifdef CODE_LOCK_AUTORELOCK_EN
                else if (r_tmr == '0) begin
                    w_state_nxt = S_LOCKED;
                end else begin
                    w_tmr_nxt = r_tmr - c_TMR_W'(1);
                end
`endif
            end
            S_LOCKOUT: begin
                w_count_nxt = '0;
                if (r_tmr == '0) begin
                    w_state_nxt = S_LOCKED;
                    w_tries_nxt = c_MAX_TRIES;
                end else begin
                    w_tmr_nxt = r_tmr - c_TMR_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_LOCKED;
                w_count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_LOCKED;
            r_buf   <= '0;
            r_count <= '0;
            r_tries <= c_MAX_TRIES;
            r_tmr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_tries <= w_tries_nxt;
            r_tmr   <= w_tmr_nxt;
            if (w_wr_en) begin
                r_buf[int'(w_wr_idx)*DIGIT_W +: DIGIT_W] <= digit;
            end
        end
    end

    assign state       = r_state;
    assign unlocked    = (r_state == S_UNLOCKED);
    assign error       = (r_state == S_ERROR);
    assign lockout     = (r_state == S_LOCKOUT);
    assign digit_count = r_count;
    assign tries_left  = r_tries;

endmodule

`default_nettype wire

// File: tb/tb_code_lock_fsm.sv
//------------------------------------------------------------------------------
// Module   : tb_code_lock_fsm
// Brief    : Directed self-checking bench for code_lock_fsm at default params.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_code_lock_fsm;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        digit_valid = 1'b0;
    logic [3:0]  digit = 4'h0;
    logic [15:0] code = 16'h4321;
    logic        clear = 1'b0;
    logic [2:0]  state;
    logic        unlocked;
    logic        error;
    logic        lockout;
    logic [2:0]  digit_count;
    logic [1:0]  tries_left;

    int n_cmp = 0;
    int n_bad = 0;

    code_lock_fsm dut (
        .clk         (clk),
        .reset       (reset),
        .digit_valid (digit_valid),
        .digit       (digit),
        .code        (code),
        .clear       (clear),
        .state       (state),
        .unlocked    (unlocked),
        .error       (error),
        .lockout     (lockout),
        .digit_count (digit_count),
        .tries_left  (tries_left)
    );

    always #5 clk = ~clk;

    // One clock with the given inputs; outputs are sampled 1 ns after the edge.
    task automatic cyc(input logic dv, input logic [3:0] d, input logic clr);
        digit_valid = dv;
        digit       = d;
        clear       = clr;
        @(posedge clk);
        #1;
        digit_valid = 1'b0;
        clear       = 1'b0;
    endtask

    task automatic enter4(input logic [15:0] digits);
        for (int i = 0; i < 4; i++) cyc(1'b1, digits[i*4 +: 4], 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc(1'b0, 4'h0, 1'b0);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (state !== 3'b000) begin n_bad++; $display("FAIL reset_state: got %b want 000", state); end
        n_cmp++;
        if (digit_count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", digit_count); end
        n_cmp++;
        if (tries_left !== 2'd3) begin n_bad++; $display("FAIL reset_tries: got %0d want 3", tries_left); end
        n_cmp++;
        if ({unlocked, error, lockout} !== 3'b000) begin
            n_bad++; $display("FAIL reset_flags: got %b want 000", {unlocked, error, lockout});
        end
    endtask

    task automatic test_unlock();
        cyc(1'b1, 4'h1, 1'b0);
        n_cmp++;
        if ({state, digit_count} !== {3'b001, 3'd1}) begin
            n_bad++; $display("FAIL first_digit: got state %b count %0d want 001/1", state, digit_count);
        end
        cyc(1'b1, 4'h2, 1'b0);
        cyc(1'b0, 4'h7, 1'b0);
        n_cmp++;
        if ({state, digit_count} !== {3'b001, 3'd2}) begin
            n_bad++; $display("FAIL idle_hold: got state %b count %0d want 001/2", state, digit_count);
        end
        cyc(1'b1, 4'h3, 1'b0);
        cyc(1'b1, 4'h4, 1'b0);
        n_cmp++;
        if ({state, digit_count} !== {3'b010, 3'd0}) begin
            n_bad++; $display("FAIL verify_entry: got state %b count %0d want 010/0", state, digit_count);
        end
        // clear and a digit during VERIFY must have no effect
        cyc(1'b1, 4'h9, 1'b1);
        n_cmp++;
        if ({state, unlocked, tries_left} !== {3'b100, 1'b1, 2'd3}) begin
            n_bad++; $display("FAIL unlock: got state %b unl %b tries %0d want 100/1/3", state, unlocked, tries_left);
        end
        cyc(1'b1, 4'h5, 1'b0);
        n_cmp++;
        if ({state, digit_count} !== {3'b100, 3'd0}) begin
            n_bad++; $display("FAIL unlocked_ignores_digit: got state %b count %0d want 100/0", state, digit_count);
        end
        cyc(1'b0, 4'h0, 1'b1);
        n_cmp++;
        if ({state, unlocked} !== {3'b000, 1'b0}) begin
            n_bad++; $display("FAIL unlocked_clear: got state %b unl %b want 000/0", state, unlocked);
        end
    endtask

    task automatic test_error();
        enter4(16'h5321);
        cyc(1'b1, 4'h1, 1'b1);
        n_cmp++;
        if ({state, error, tries_left} !== {3'b011, 1'b1, 2'd2}) begin
            n_bad++; $display("FAIL error_state: got state %b err %b tries %0d want 011/1/2", state, error, tries_left);
        end
        cyc(1'b1, 4'h1, 1'b0);
        n_cmp++;
        if ({state, error, digit_count, tries_left} !== {3'b000, 1'b0, 3'd0, 2'd2}) begin
            n_bad++; $display("FAIL error_exit: got state %b err %b count %0d tries %0d want 000/0/0/2",
                              state, error, digit_count, tries_left);
        end
    endtask

    task automatic test_lockout();
        int lock_cycles;
        do_reset();
        enter4(16'h0001); cyc(1'b0, 4'h0, 1'b0); cyc(1'b0, 4'h0, 1'b0);
        enter4(16'h0002); cyc(1'b0, 4'h0, 1'b0); cyc(1'b0, 4'h0, 1'b0);
        n_cmp++;
        if ({state, tries_left} !== {3'b000, 2'd1}) begin
            n_bad++; $display("FAIL two_wrong: got state %b tries %0d want 000/1", state, tries_left);
        end
        enter4(16'h0003);
        cyc(1'b0, 4'h0, 1'b0);
        n_cmp++;
        if ({state, lockout, tries_left} !== {3'b101, 1'b1, 2'd0}) begin
            n_bad++; $display("FAIL lockout_entry: got state %b lk %b tries %0d want 101/1/0", state, lockout, tries_left);
        end
        lock_cycles = 1;
        for (int i = 1; i < 16; i++) begin
            cyc(1'b1, 4'(i), 1'(i));
            if (lockout === 1'b1 && digit_count === 3'd0) lock_cycles++;
        end
        n_cmp++;
        if (lock_cycles !== 16) begin n_bad++; $display("FAIL lockout_len: got %0d cycles want 16", lock_cycles); end
        cyc(1'b0, 4'h0, 1'b0);
        n_cmp++;
        if ({state, lockout, tries_left} !== {3'b000, 1'b0, 2'd3}) begin
            n_bad++; $display("FAIL lockout_exit: got state %b lk %b tries %0d want 000/0/3", state, lockout, tries_left);
        end
    endtask

    task automatic test_clear();
        cyc(1'b1, 4'h1, 1'b0);
        cyc(1'b1, 4'h2, 1'b0);
        cyc(1'b1, 4'h3, 1'b1);
        n_cmp++;
        if ({state, digit_count, tries_left} !== {3'b000, 3'd0, 2'd3}) begin
            n_bad++; $display("FAIL clear_wins: got state %b count %0d tries %0d want 000/0/3",
                              state, digit_count, tries_left);
        end
        enter4(16'h4321);
        cyc(1'b0, 4'h0, 1'b0);
        n_cmp++;
        if (unlocked !== 1'b1) begin n_bad++; $display("FAIL clear_reentry: got unl %b want 1", unlocked); end
    endtask

    task automatic test_relock();
`ifdef CODE_LOCK_AUTORELOCK_EN
        for (int i = 0; i < 7; i++) cyc(1'b0, 4'h0, 1'b0);
        n_cmp++;
        if (state !== 3'b100) begin n_bad++; $display("FAIL relock_early: got %b want 100", state); end
        cyc(1'b0, 4'h0, 1'b0);
        n_cmp++;
        if (state !== 3'b000) begin n_bad++; $display("FAIL relock_time: got %b want 000", state); end
`else
        for (int i = 0; i < 100; i++) cyc(1'b0, 4'h0, 1'b0);
        n_cmp++;
        if (state !== 3'b100) begin n_bad++; $display("FAIL no_relock: got %b want 100", state); end
        cyc(1'b0, 4'h0, 1'b1);
`endif
    endtask

    task automatic test_reset_midway();
        cyc(1'b1, 4'h1, 1'b0);
        cyc(1'b1, 4'h2, 1'b0);
        reset = 1'b0;
        cyc(1'b1, 4'h3, 1'b0);
        reset = 1'b1;
        n_cmp++;
        if ({state, digit_count, tries_left} !== {3'b000, 3'd0, 2'd3}) begin
            n_bad++; $display("FAIL reset_input: got state %b count %0d tries %0d want 000/0/3",
                              state, digit_count, tries_left);
        end
        for (int k = 0; k < 3; k++) begin
            enter4(16'h9999); cyc(1'b0, 4'h0, 1'b0); cyc(1'b0, 4'h0, 1'b0);
        end
        reset = 1'b0;
        cyc(1'b1, 4'h1, 1'b0);
        reset = 1'b1;
        n_cmp++;
        if ({state, digit_count, tries_left, lockout} !== {3'b000, 3'd0, 2'd3, 1'b0}) begin
            n_bad++; $display("FAIL reset_lockout: got state %b count %0d tries %0d lk %b want 000/0/3/0",
                              state, digit_count, tries_left, lockout);
        end
    endtask

    task automatic test_code_sampling();
        // code changes before VERIFY; the value present in VERIFY is used
        code = 16'h0000;
        enter4(16'h8765);
        code = 16'h8765;
        cyc(1'b0, 4'h0, 1'b0);
        n_cmp++;
        if (state !== 3'b100) begin n_bad++; $display("FAIL code_sample: got %b want 100", state); end
        cyc(1'b0, 4'h0, 1'b1);
        code = 16'h4321;
    endtask

    initial begin
        test_reset();
        test_unlock();
        test_error();
        test_lockout();
        test_clear();
        test_relock();
        test_reset_midway();
        test_code_sampling();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
